// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite encodings and command types shared by the queued master
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [2:0]            size;
    } ahb_cmd_t;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_ERR1   = 1'b1
    } err_state_e;

    // Flat command width for instances whose address/data widths differ from the struct defaults.
    function automatic int cmd_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + 3;
    endfunction

endpackage

// File: rtl/ahb_cmd_fifo.sv
// rtl/ahb_cmd_fifo.sv - synchronous command FIFO with occupancy count
module ahb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign wr_ready_o = (count_q != CNT_W'(DEPTH));
    assign rd_valid_o = (count_q != '0);
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = rd_pop_i && rd_valid_o;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ahb_lite_master_q.sv
// rtl/ahb_lite_master_q.sv - queued AHB-Lite master issuing pipelined SINGLE transfers
module ahb_lite_master_q
    import ahb_lite_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter int         DEPTH     = 4,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [DATA_W-1:0]       cmd_wdata,
    input  logic [2:0]              cmd_size,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    rsp_valid,
    output logic                    rsp_write,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_W-1:0]       HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [1:0]              HTRANS,
    output logic                    HMASTLOCK,
    output logic [DATA_W-1:0]       HWDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    input  logic [DATA_W-1:0]       HRDATA
);

    localparam int CMD_W = cmd_width(ADDR_W, DATA_W);

    logic [CMD_W-1:0]  fifo_wdata;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              fifo_valid;
    logic              fifo_pop;
    logic              load_head;

    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic [2:0]        head_size;

    err_state_e        state_q, state_d;
    logic              addr_valid_q, addr_valid_d;
    logic              addr_write_q, addr_write_d;
    logic [ADDR_W-1:0] addr_addr_q, addr_addr_d;
    logic [DATA_W-1:0] addr_wdata_q, addr_wdata_d;
    logic [2:0]        addr_size_q, addr_size_d;
    logic              data_valid_q, data_valid_d;
    logic              data_write_q, data_write_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    assign fifo_wdata = {cmd_write, cmd_addr, cmd_wdata, cmd_size};
    assign {head_write, head_addr, head_wdata, head_size} = fifo_rdata;

    ahb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk_i      (HCLK),
        .rst_ni     (HRESETn),
        .wr_valid_i (cmd_valid),
        .wr_ready_o (cmd_ready),
        .wr_data_i  (fifo_wdata),
        .rd_valid_o (fifo_valid),
        .rd_pop_i   (fifo_pop),
        .rd_data_o  (fifo_rdata),
        .count_o    (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        addr_valid_d = addr_valid_q;
        addr_write_d = addr_write_q;
        addr_addr_d  = addr_addr_q;
        addr_wdata_d = addr_wdata_q;
        addr_size_d  = addr_size_q;
        data_valid_d = data_valid_q;
        data_write_d = data_write_q;
        hwdata_d     = hwdata_q;
        rsp_valid_d  = 1'b0;
        rsp_write_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        load_head    = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_NORMAL: begin
                if (HREADY) begin
                    if (data_valid_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_write_d = data_write_q;
                        rsp_err_d   = (HRESP == HRESP_ERROR);
                        rsp_rdata_d = (data_write_q || HRESP) ? '0 : HRDATA;
                    end
                    data_valid_d = addr_valid_q;
                    data_write_d = addr_write_q;
                    if (addr_valid_q && addr_write_q) begin
                        hwdata_d = addr_wdata_q;
                    end
                    load_head = 1'b1;
                end else if (data_valid_q && (HRESP == HRESP_ERROR)) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                // HTRANS was IDLE this cycle, so the ADDR command stays put and re-issues next cycle.
                if (HREADY) begin
                    rsp_valid_d  = 1'b1;
                    rsp_write_d  = data_write_q;
                    rsp_err_d    = 1'b1;
                    data_valid_d = 1'b0;
                    load_head    = !addr_valid_q;
                    state_d      = ST_NORMAL;
                end
            end
        endcase

        if (load_head) begin
            fifo_pop     = fifo_valid;
            addr_valid_d = fifo_valid;
            if (fifo_valid) begin
                addr_write_d = head_write;
                addr_addr_d  = head_addr;
                addr_wdata_d = head_wdata;
                addr_size_d  = head_size;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_NORMAL;
            addr_valid_q <= 1'b0;
            addr_write_q <= 1'b0;
            addr_addr_q  <= '0;
            addr_wdata_q <= '0;
            addr_size_q  <= '0;
            data_valid_q <= 1'b0;
            data_write_q <= 1'b0;
            hwdata_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_valid_q <= addr_valid_d;
            addr_write_q <= addr_write_d;
            addr_addr_q  <= addr_addr_d;
            addr_wdata_q <= addr_wdata_d;
            addr_size_q  <= addr_size_d;
            data_valid_q <= data_valid_d;
            data_write_q <= data_write_d;
            hwdata_q     <= hwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_write_q  <= rsp_write_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign HTRANS    = (addr_valid_q && (state_q == ST_NORMAL)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = addr_addr_q;
    assign HWRITE    = addr_write_q;
    assign HSIZE     = addr_size_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master_q.sv
// tb/tb_ahb_lite_master_q.sv - directed and randomized bench for the queued AHB-Lite master
module tb_ahb_lite_master_q;
    import ahb_lite_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int N_RAND = 3000;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
    } tcmd_t;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [2:0]        cmd_size;
    logic [$clog2(DEPTH):0] fifo_count;
    logic              rsp_valid, rsp_write, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]        HSIZE, HBURST;
    logic [3:0]        HPROT;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HWDATA, HRDATA;

    int vectors     = 0;
    int miscompares = 0;

    tcmd_t exp_q[$];
    tcmd_t dp_cmd, c;
    bit    dp_act, err2, rsp_due;
    int    waits, nrsp, naddr;
    logic  e_w, e_e;
    logic [31:0] e_d;
    bit    saw_rsp, saw_tr;

    ahb_lite_master_q #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .HPROT_VAL(4'b0011)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .fifo_count(fifo_count),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] s);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_size  = s;
    endtask

    task automatic do_reset();
        drive_cmd(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        HRDATA  = '0;
        HRESETn = 1'b0;
        step();
        step();
        HRESETn = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_htrans"}, HTRANS, HTRANS_IDLE);
        chk({tag, "_haddr"}, HADDR, 0);
        chk({tag, "_hwrite"}, HWRITE, 0);
        chk({tag, "_hsize"}, HSIZE, 0);
        chk({tag, "_hburst"}, HBURST, 3'b000);
        chk({tag, "_hprot"}, HPROT, 4'b0011);
        chk({tag, "_hmastlock"}, HMASTLOCK, 0);
        chk({tag, "_hwdata"}, HWDATA, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_write"}, rsp_write, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset values, then a single write with zero wait states.
        HRESETn = 1'b0;
        do_reset();
        HRESETn = 1'b0;
        #1;
        chk_reset("rst");
        HRESETn = 1'b1;
        step();
        drive_cmd(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
        step();
        drive_cmd(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        chk("t1_count", fifo_count, 1);
        chk("t1_idle_k", HTRANS, HTRANS_IDLE);
        step();
        chk("t1_htrans", HTRANS, HTRANS_NONSEQ);
        chk("t1_hwrite", HWRITE, 1);
        chk("t1_haddr", HADDR, 32'h10);
        chk("t1_hsize", HSIZE, 3'd2);
        step();
        chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
        chk("t1_rsp_early", rsp_valid, 0);
        step();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_write", rsp_write, 1);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        step();
        chk("t1_rsp_once", rsp_valid, 0);

        // Read then write back-to-back: address phase overlaps the read data phase.
        do_reset();
        HRDATA = 32'hCAFEF00D;
        drive_cmd(1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
        step();
        drive_cmd(1'b1, 1'b1, 32'h24, 32'h55, 3'd2);
        step();
        drive_cmd(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        chk("t2_rd_haddr", HADDR, 32'h20);
        chk("t2_rd_hwrite", HWRITE, 0);
        step();
        chk("t2_wr_haddr", HADDR, 32'h24);
        chk("t2_wr_htrans", HTRANS, HTRANS_NONSEQ);
        step();
        chk("t2_rsp1_valid", rsp_valid, 1);
        chk("t2_rsp1_write", rsp_write, 0);
        chk("t2_rsp1_rdata", rsp_rdata, 32'hCAFEF00D);
        chk("t2_hwdata", HWDATA, 32'h55);
        step();
        chk("t2_rsp2_valid", rsp_valid, 1);
        chk("t2_rsp2_write", rsp_write, 1);
        chk("t2_rsp2_rdata", rsp_rdata, 0);

        // Two wait states during a write data phase with a read pending in ADDR.
        do_reset();
        drive_cmd(1'b1, 1'b1, 32'h30, 32'h1234, 3'd2);
        step();
        drive_cmd(1'b1, 1'b0, 32'h34, 32'h0, 3'd2);
        step();
        drive_cmd(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        chk("t3_wr_haddr", HADDR, 32'h30);
        step();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_haddr_hold", HADDR, 32'h34);
            chk("t3_htrans_hold", HTRANS, HTRANS_NONSEQ);
            chk("t3_hwdata_hold", HWDATA, 32'h1234);
            chk("t3_no_rsp", rsp_valid, 0);
            if (i < 2) step();
        end
        HREADY = 1'b1;
        HRDATA = 32'h0BADF00D;
        step();
        chk("t3_rsp_wr_valid", rsp_valid, 1);
        chk("t3_rsp_wr_write", rsp_write, 1);
        chk("t3_hwdata_rd", HWDATA, 32'h1234);
        step();
        chk("t3_rsp_rd_valid", rsp_valid, 1);
        chk("t3_rsp_rd_rdata", rsp_rdata, 32'h0BADF00D);
        step();
        chk("t3_rsp_done", rsp_valid, 0);

        // ERROR on a read while a write to 0x40 sits in its address phase.
        do_reset();
        HRDATA = 32'hFFFF_FFFF;
        drive_cmd(1'b1, 1'b0, 32'h3C, 32'h0, 3'd2);
        step();
        drive_cmd(1'b1, 1'b1, 32'h40, 32'h77, 3'd2);
        step();
        drive_cmd(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        chk("t4_rd_haddr", HADDR, 32'h3C);
        step();
        chk("t4_wr_haddr", HADDR, 32'h40);
        chk("t4_wr_nonseq", HTRANS, HTRANS_NONSEQ);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        step();
        chk("t4_err1_idle", HTRANS, HTRANS_IDLE);
        chk("t4_err1_haddr", HADDR, 32'h40);
        chk("t4_err1_no_rsp", rsp_valid, 0);
        HREADY = 1'b1;
        step();
        chk("t4_err_rsp_valid", rsp_valid, 1);
        chk("t4_err_rsp_err", rsp_err, 1);
        chk("t4_err_rsp_write", rsp_write, 0);
        chk("t4_err_rsp_rdata", rsp_rdata, 0);
        chk("t4_reissue_nonseq", HTRANS, HTRANS_NONSEQ);
        chk("t4_reissue_haddr", HADDR, 32'h40);
        chk("t4_reissue_hwrite", HWRITE, 1);
        HRESP = 1'b0;
        step();
        chk("t4_hwdata", HWDATA, 32'h77);
        chk("t4_no_rsp", rsp_valid, 0);
        step();
        chk("t4_wr_rsp_valid", rsp_valid, 1);
        chk("t4_wr_rsp_err", rsp_err, 0);
        chk("t4_wr_rsp_write", rsp_write, 1);

        // DEPTH+1 pushes with HREADY low: the last one must be refused.
        do_reset();
        HREADY = 1'b0;
        HRDATA = 32'h5A5A0000;
        for (int i = 0; i <= DEPTH; i++) begin
            drive_cmd(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 3'd2);
            chk("t5_cmd_ready", cmd_ready, (i < DEPTH) ? 1 : 0);
            step();
        end
        drive_cmd(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        chk("t5_full_count", fifo_count, DEPTH);
        chk("t5_full_ready", cmd_ready, 0);
        chk("t5_idle", HTRANS, HTRANS_IDLE);
        HREADY = 1'b1;
        nrsp  = 0;
        naddr = 0;
        for (int i = 0; i < 20; i++) begin
            if (HTRANS == HTRANS_NONSEQ) begin
                chk("t5_order_haddr", HADDR, 32'h100 + 32'(4 * naddr));
                naddr++;
            end
            if (rsp_valid) nrsp++;
            step();
        end
        chk("t5_nrsp", nrsp, DEPTH);
        chk("t5_drained_count", fifo_count, 0);

        // Reset mid-burst with three commands still queued.
        do_reset();
        HREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cmd(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 3'd2);
            step();
        end
        drive_cmd(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        HREADY = 1'b1;
        step();
        chk("t6_pre_count", fifo_count, DEPTH - 1);
        chk("t6_pre_nonseq", HTRANS, HTRANS_NONSEQ);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_reset("t6_async");
        step();
        HRESETn = 1'b1;
        saw_rsp = 0;
        saw_tr  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid) saw_rsp = 1;
            if (HTRANS != HTRANS_IDLE) saw_tr = 1;
        end
        chk("t6_no_rsp_after", saw_rsp, 0);
        chk("t6_no_transfer_after", saw_tr, 0);
        chk("t6_count_after", fifo_count, 0);

        // Randomized traffic against an in-order scoreboard and a behavioural slave.
        do_reset();
        dp_act  = 0;
        err2    = 0;
        rsp_due = 0;
        waits   = 0;
        for (int cyc = 0; cyc < N_RAND + 400; cyc++) begin
            chk("r_rsp_valid", rsp_valid, rsp_due);
            if (rsp_due) begin
                chk("r_rsp_write", rsp_write, e_w);
                chk("r_rsp_rdata", rsp_rdata, e_d);
                chk("r_rsp_err", rsp_err, e_e);
            end
            rsp_due = 0;
            if (cyc >= N_RAND && exp_q.size() == 0 && !dp_act && !err2) break;

            drive_cmd((cyc < N_RAND) && ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, 3'($urandom_range(0, 2)));
            cmd_addr = cmd_addr & ~((32'd1 << cmd_size) - 32'd1);
            if (cmd_valid && cmd_ready) begin
                c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata; c.s = cmd_size;
                exp_q.push_back(c);
            end

            if (err2) begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
                chk("r_err1_idle", HTRANS, HTRANS_IDLE);
                rsp_due = 1; e_w = dp_cmd.w; e_d = 0; e_e = 1;
                dp_act = 0;
                err2   = 0;
            end else if (dp_act) begin
                if (dp_cmd.w) chk("r_hwdata", HWDATA, dp_cmd.d);
                if (waits == 0 && $urandom_range(0, 9) == 0) begin
                    HREADY = 1'b0;
                    HRESP  = 1'b1;
                    err2   = 1;
                end else if (waits < 2 && $urandom_range(0, 3) == 0) begin
                    HREADY = 1'b0;
                    HRESP  = 1'b0;
                    waits++;
                end else begin
                    HREADY = 1'b1;
                    HRESP  = 1'b0;
                    HRDATA = $urandom;
                    rsp_due = 1; e_w = dp_cmd.w; e_d = dp_cmd.w ? 32'h0 : HRDATA; e_e = 0;
                    dp_act = 0;
                end
            end else begin
                HREADY = ($urandom_range(0, 7) != 0);
                HRESP  = 1'b0;
            end

            if (HREADY && HTRANS == HTRANS_NONSEQ) begin
                if (exp_q.size() == 0) begin
                    chk("r_spurious_nonseq", 1, 0);
                end else begin
                    c = exp_q.pop_front();
                    chk("r_haddr", HADDR, c.a);
                    chk("r_hwrite", HWRITE, c.w);
                    chk("r_hsize", HSIZE, c.s);
                    chk("r_hburst", HBURST, 3'b000);
                    chk("r_hprot", HPROT, 4'b0011);
                    dp_act = 1;
                    dp_cmd = c;
                    waits  = 0;
                end
            end
            step();
        end
        chk("r_all_issued", exp_q.size(), 0);
        chk("r_no_pending_dp", dp_act, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master_q.md
Name: ahb_lite_master_q

Overview:
Synthesizable, parametrised AHB-Lite master with an internal command queue. It is the successor to the task-driven testbench master: commands enter through a valid/ready port, are buffered in a FIFO of DEPTH entries and issued as pipelined SINGLE transfers. Address phase N+1 overlaps data phase N. Every command produces exactly one in-order response carrying read data and the error flag. It sits between a local requester (DMA, CPU shim, bench driver) and the AHB-Lite interconnect.

Parameters:
ADDR_W, 32, HADDR and command address width
DATA_W, 32, HWDATA/HRDATA width; legal values 8, 16, 32, 64
DEPTH, 4, command FIFO entries; power of 2, minimum 2
HPROT_VAL, 4'b0011, constant HPROT value driven on every transfer

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address (caller guarantees alignment to cmd_size)
cmd_wdata  in  DATA_W  write data
cmd_size  in  3  HSIZE encoding
fifo_count  out  $clog2(DEPTH)+1  occupied entries
rsp_valid  out  1  one-cycle response strobe
rsp_write  out  1  direction of the responded command
rsp_rdata  out  DATA_W  captured HRDATA; 0 for writes
rsp_err  out  1  transfer ended with ERROR
HADDR  out  ADDR_W  address
HWRITE  out  1  direction
HSIZE  out  3  size
HBURST  out  3  always SINGLE
HPROT  out  4  always HPROT_VAL
HTRANS  out  2  IDLE or NONSEQ only
HMASTLOCK  out  1  always 0
HWDATA  out  DATA_W  write data
HREADY  in  1  transfer ready
HRESP  in  1  0 = OKAY, 1 = ERROR
HRDATA  in  DATA_W  read data

Behaviour:
- Reset values (asynchronous, taking effect immediately): HTRANS = IDLE, HADDR = 0, HWRITE = 0, HSIZE = 0, HBURST = SINGLE, HPROT = HPROT_VAL, HMASTLOCK = 0, HWDATA = 0, rsp_* = 0, FIFO empty, cmd_ready = 1.
- Reset mid-transfer drops all queued and in-flight commands. No responses are generated for them.
- Push: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_ready = (fifo_count != DEPTH) and does not depend on a same-cycle pop. Writes offered while full are not accepted.
- Pipeline registers:
  - ADDR stage: drives HADDR/HWRITE/HSIZE; HTRANS = NONSEQ while valid, IDLE otherwise.
  - DATA stage: holds the direction and wdata of the transfer in its data phase.
- Advance rule: on an edge with HREADY = 1:
  - ADDR moves to DATA.
  - The FIFO head, if present, is loaded into ADDR.
  - Otherwise ADDR becomes invalid and HTRANS = IDLE.
- With HREADY = 0 all address/control outputs and HWDATA hold stable.
- Latency, zero wait states:
  - Command accepted at edge k.
  - NONSEQ driven in cycle k+1.
  - Data phase in cycle k+2.
  - rsp_valid in cycle k+3.
- Throughput: 1 transfer per cycle while the FIFO is non-empty.
- HWDATA is driven from the DATA stage during the write data phase. During read data phases it holds its last value.
- Response: registered. On the edge that completes a data phase (HREADY = 1, HRESP = 0), the next cycle has rsp_valid = 1, rsp_write = DATA.write, rsp_rdata = HRDATA (reads) or 0 (writes), rsp_err = 0. No backpressure.
- ERROR handling, FSM states NORMAL → ERR1 → NORMAL:
  - ERR1 is entered when HREADY = 0 and HRESP = 1 are sampled during a data phase.
  - In ERR1, HTRANS is forced to IDLE, cancelling the pending ADDR transfer. The cancelled command stays in ADDR and is not lost.
  - On the second error cycle (HREADY = 1, HRESP = 1): the errored command responds with rsp_err = 1 and rsp_rdata = 0. The retained command re-issues NONSEQ in the following cycle, then the FSM returns to NORMAL.
- Responses are always in command order, one per command, including errored ones.
- Simultaneous push and pop: fifo_count is unchanged. Push to an empty FIFO is visible to ADDR no earlier than the next edge (no bypass).

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HBURST encodings.
  - HSIZE encodings.
  - HRESP OKAY/ERROR.
  - ahb_cmd_t struct {write, addr, wdata, size}, parametrised via localparams.
- Sub-module ahb_cmd_fifo: synchronous FIFO with count, parametrised width and DEPTH, async active-low reset.
- The top level holds the pipeline registers, the ERR FSM and the response register.

Test Plan:
- Reset, then push write (addr 0x10, data 0xDEADBEEF, size 2) with HREADY = 1 → NONSEQ/HWRITE = 1/HADDR = 0x10 in cycle 1; HWDATA = 0xDEADBEEF in cycle 2; rsp_valid with rsp_err = 0 in cycle 3.
- Push read(0x20) then write(0x24, 0x55) back-to-back → HADDR 0x24 is driven during the read data phase; rsp 1 has rsp_rdata = HRDATA (0xCAFEF00D) and rsp_write = 0; rsp 2 has rsp_write = 1, in order.
- Insert 2 wait states (HREADY = 0) during a write data phase → HADDR/HTRANS/HWDATA are constant for both cycles; a single response follows after HREADY = 1.
- Slave ERROR on a read while a write to 0x40 is in its address phase → HTRANS = IDLE in cycle ERR1; rsp_err = 1; write to 0x40 re-issued NONSEQ afterwards and completes OK.
- Push DEPTH + 1 commands with HREADY held 0 → cmd_ready drops at fifo_count = DEPTH; extra command not accepted; all DEPTH commands complete once HREADY = 1.
- Assert HRESETn low mid-burst with 3 queued commands → outputs return to reset values immediately; no rsp_valid afterwards; fifo_count = 0.
